// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: runs a WIDTH-bit add through one registered 1-bit full-adder cell, bits LSB first.
// Latency: 2*WIDTH+1 edges from accept to the done cycle; a new operation can start in the done cycle.
// Backpressure: none. start is sampled only while idle; start while busy is dropped, not queued.

// simple_adder: 1-bit full adder with registered inputs and registered outputs.
// Inputs driven in cycle T are captured at the end of T. The result is captured at the end of T+1.
// No flow control. The cell is free-running on every clock.
module simple_adder (
  input  logic clock,
  input  logic reset,
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic a_q, b_q, c_q;
  logic sum_q, cout_q;

  // Input stage and result stage; both are cleared by the shared reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      c_q    <= 1'b0;
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      a_q    <= a_i;
      b_q    <= b_i;
      c_q    <= cin_i;
      sum_q  <= a_q ^ b_q ^ c_q;
      cout_q <= (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The bit index needs at least one bit, even when WIDTH is 1.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             phase_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             cell_a_d;
  logic             cell_b_d;
  logic             cell_c_d;
  logic             cell_sum;
  logic             cell_cout;
  logic [WIDTH-1:0] sum_d;

  // The cell sees operand bits only in drive cycles. Gap cycles feed zeros so the
  // cell's outputs are deterministic, but those outputs are never used. Bit 0 takes
  // the captured carry-in. Later bits take the cell's carry, which holds bit i-1's
  // result during bit i's drive cycle.
  always_comb begin
    cell_a_d = 1'b0;
    cell_b_d = 1'b0;
    cell_c_d = 1'b0;
    if (state_q == RUN && !phase_q) begin
      cell_a_d = a_q[idx_q];
      cell_b_d = b_q[idx_q];
      cell_c_d = (idx_q == '0) ? carry_q : cell_cout;
    end
  end

  simple_adder u_cell (
    .clock  (clock),
    .reset  (reset),
    .a_i    (cell_a_d),
    .b_i    (cell_b_d),
    .cin_i  (cell_c_d),
    .sum_o  (cell_sum),
    .cout_o (cell_cout)
  );

  // Final result: lower bits come from the shadow register, and the top bit comes
  // straight from the cell during FINISH.
  always_comb begin
    sum_d            = shadow_q;
    sum_d[WIDTH-1]   = cell_sum;
  end

  // Sequencer: accept, per-bit drive/gap cadence, result load and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!phase_q) begin
            // During bit i's drive cycle, the cell output holds bit i-1's sum.
            if (idx_q != '0) begin
              shadow_q[idx_q - 1'b1] <= cell_sum;
            end
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= FINISH;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        FINISH: begin
          sum_q   <= sum_d;
          cout_q  <= cell_cout;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances checked against plain a+b+cin arithmetic.
// Inputs are driven and outputs sampled on the falling edge. Latency is counted in rising edges after the accept edge.
// Every wait loop has a cycle budget, and an expired budget shows up as a failed latency check.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clock (clk), .reset (reset), .start (start), .a (a), .b (b), .cin (cin),
    .busy (busy), .done (done), .sum (sum), .cout (cout)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clock (clk), .reset (reset), .start (start1), .a (a1), .b (b1), .cin (cin1),
    .busy (busy1), .done (done1), .sum (sum1), .cout (cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge. Runs one accept, optionally with garbage start/operands
  // during the run, and returns at the falling edge where done is seen. lat is the
  // number of rising edges after the accept edge.
  task automatic add8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                      input bit junk, output int lat, output logic [7:0] rs, output logic rc);
    logic [7:0] held;
    bit         busy_ok, hold_ok;
    a = ta; b = tbv; cin = tc; start = 1'b1;
    @(negedge clk);
    held = sum; busy_ok = 1'b1; hold_ok = 1'b1; lat = 0;
    while (!done && lat < 60) begin
      if (junk) begin
        start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (sum !== held) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("busy_during_run", 32'(busy_ok), 32'd1);
    check("sum_held_during_run", 32'(hold_ok), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    rs = sum; rc = cout;
  endtask

  task automatic verify8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                         input int lat, input logic [7:0] rs, input logic rc);
    int exp;
    exp = int'(ta) + int'(tbv) + int'(tc);
    check("sum8", 32'(rs), 32'(exp % 256));
    check("cout8", 32'(rc), 32'(exp / 256));
    check("latency8", 32'(lat), 32'd17);
  endtask

  task automatic add1(input logic ta, input logic tbv, input logic tc);
    int lat, exp;
    a1 = ta; b1 = tbv; cin1 = tc; start1 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done1 && lat < 20) begin
      start1 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0;
    exp = int'(ta) + int'(tbv) + int'(tc);
    check("sum1", 32'(sum1), 32'(exp % 2));
    check("cout1", 32'(cout1), 32'(exp / 2));
    check("latency1", 32'(lat), 32'd3);
    check("busy1_at_done", 32'(busy1), 32'd0);
  endtask

  initial begin
    int lat, extra;
    logic [7:0] rs, ta, tbv;
    logic rc, tc;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_w1", {28'd0, busy1, done1, sum1, cout1}, 32'd0);

    // Directed cases.
    add8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, rs, rc);
    verify8(8'h5A, 8'h3C, 1'b0, lat, rs, rc);
    check("sum_5a_3c", 32'(rs), 32'h96);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    add8(8'hFF, 8'h01, 1'b0, 1'b0, lat, rs, rc);
    check("ff_01_sum", 32'(rs), 32'h00);
    check("ff_01_cout", 32'(rc), 32'd1);
    add8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, rs, rc);
    check("ff_ff_1_sum", 32'(rs), 32'hFF);
    check("ff_ff_1_cout", 32'(rc), 32'd1);

    // start held during the run with changing operands must be ignored.
    add8(8'h12, 8'h34, 1'b0, 1'b1, lat, rs, rc);
    verify8(8'h12, 8'h34, 1'b0, lat, rs, rc);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no_extra_done", 32'(extra), 32'd0);

    // Back-to-back: accept in the done cycle. The second call checks that sum holds.
    add8(8'h80, 8'h81, 1'b0, 1'b0, lat, rs, rc);
    verify8(8'h80, 8'h81, 1'b0, lat, rs, rc);
    add8(8'h01, 8'h02, 1'b1, 1'b0, lat, rs, rc);
    verify8(8'h01, 8'h02, 1'b1, lat, rs, rc);
    check("b2b_sum", 32'(rs), 32'h04);

    // Reset during bit 3: the cycle after the edge following accept+6.
    a = 8'hC3; b = 8'h5E; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    add8(8'hC3, 8'h5E, 1'b1, 1'b0, lat, rs, rc);
    verify8(8'hC3, 8'h5E, 1'b1, lat, rs, rc);

    // Random WIDTH=8 trials with random junk and random idle gaps.
    for (int i = 0; i < 1000; i++) begin
      ta = 8'($urandom); tbv = 8'($urandom); tc = 1'($urandom);
      add8(ta, tbv, tc, ($urandom_range(0, 3) == 0), lat, rs, rc);
      verify8(ta, tbv, tc, lat, rs, rc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Random WIDTH=1 trials.
    for (int i = 0; i < 1000; i++) begin
      add1(1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
